// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
// A small TX FIFO sits behind a 16-byte register window on the data-memory bus.
// A four-state shifter drains the FIFO onto the tx pin.
// Register window (offsets from BASE_ADDR):
//   +0x0 TXDATA  write pushes a byte, reads 0
//   +0x4 STATUS  {count[8:4], overflow, busy, empty, full}; writing 1 to bit3 clears overflow
//   +0x8 BAUDDIV clock cycles per bit, clamped to a minimum of 2
//   +0xC         reserved, reads 0
// FIFO_DEPTH must be a power of two between 2 and 16.
// The pointers then wrap naturally, and the count fits the 5-bit STATUS field.

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFE0,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_data_out,
    output logic        tx,
    output logic        irq_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      RESET_DIV  = 16'(CLKS_PER_BIT);
    localparam logic [15:0]      MIN_DIV    = 16'd2;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Bus decode
    logic       w_hit;
    logic [1:0] w_off;
    logic       w_wrTx;
    logic       w_wrStatus;
    logic       w_wrBaud;

    // FIFO
    logic [7:0]       r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_pushOk;
    logic             w_overflowSet;
    logic [7:0]       w_headByte;

    // Registers
    logic        r_overflow;
    logic [15:0] r_baudDiv;
    logic [31:0] r_readData;
    logic [31:0] w_readData;
    logic [31:0] w_status;
    logic        r_irqEmpty;

    // Transmit engine
    logic [1:0]  r_state;
    logic [15:0] r_baudCnt;
    logic [15:0] r_frameDiv;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitIdx;
    logic        r_tx;
    logic        w_busy;

    // The store size and the byte lane are irrelevant here, because every store writes the full register.
    logic w_unused;
    assign w_unused = ^{funct3, dmem_address[1:0], dmem_data_in[31:16]};

    assign w_hit      = (dmem_address[31:4] == BASE_ADDR[31:4]);
    assign w_off      = dmem_address[3:2];
    assign w_wrTx     = dmem_wren && w_hit && (w_off == OFF_TXDATA);
    assign w_wrStatus = dmem_wren && w_hit && (w_off == OFF_STATUS);
    assign w_wrBaud   = dmem_wren && w_hit && (w_off == OFF_BAUDDIV);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_headByte = r_fifoMem[r_rdPtr];
    assign w_busy     = (r_state != S_IDLE);

    // A frame starts whenever a byte is waiting and the line is free.
    // The line is free either when idle or on the final stop-bit cycle, so back-to-back frames have no gap.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && (r_baudCnt == 16'd0)));

    // A push into a full FIFO still succeeds when the head is leaving on the same edge.
    assign w_pushOk      = w_wrTx && (!w_full || w_pop);
    assign w_overflowSet = w_wrTx && w_full && !w_pop;

    assign w_status = {23'd0, 5'(r_count), r_overflow, w_busy, w_empty, w_full};

    // FIFO storage is plain registers with no reset, because contents are meaningless once the count is zero.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_fifoMem[r_wrPtr] <= dmem_data_in[7:0];
        end
    end

    // The FIFO pointers and occupancy count track accepted pushes and engine pops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The sticky overflow flag is set by a dropped push. A same-cycle clear loses to the set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_overflowSet) begin
            r_overflow <= 1'b1;
        end else if (w_wrStatus && dmem_data_in[3]) begin
            r_overflow <= 1'b0;
        end
    end

    // The baud divisor is clamped to 2 so that every bit lasts at least two clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baudDiv <= RESET_DIV;
        end else if (w_wrBaud) begin
            r_baudDiv <= (dmem_data_in[15:0] < MIN_DIV) ? MIN_DIV : dmem_data_in[15:0];
        end
    end

    // Read mux for the register window. Anything outside the window or at the reserved offset reads as zero.
    always_comb begin
        w_readData = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_STATUS:  w_readData = w_status;
                OFF_BAUDDIV: w_readData = {16'd0, r_baudDiv};
                default:     w_readData = 32'd0;
            endcase
        end
    end

    // Read data is registered, so it shows register values from before the sampling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readData <= 32'd0;
        end else begin
            r_readData <= w_readData;
        end
    end

    // Transmit engine: start bit, eight data bits LSB first, then a stop bit.
    // The divisor is latched at each frame start, so a BAUDDIV write only affects the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baudCnt  <= 16'd0;
            r_frameDiv <= RESET_DIV;
            r_shift    <= 8'd0;
            r_bitIdx   <= 3'd0;
            r_tx       <= 1'b1;
        end else if (w_pop) begin
            r_state    <= S_START;
            r_shift    <= w_headByte;
            r_frameDiv <= r_baudDiv;
            r_baudCnt  <= r_baudDiv - 16'd1;
            r_bitIdx   <= 3'd0;
            r_tx       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                end
                S_START: begin
                    if (r_baudCnt == 16'd0) begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bitIdx  <= 3'd0;
                        r_baudCnt <= r_frameDiv - 16'd1;
                    end else begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_baudCnt == 16'd0) begin
                        r_bitIdx  <= r_bitIdx + 3'd1;
                        r_baudCnt <= r_frameDiv - 16'd1;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_baudCnt == 16'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // The empty interrupt follows the idle-and-drained condition one clock later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irqEmpty <= 1'b1;
        end else begin
            r_irqEmpty <= (r_state == S_IDLE) && w_empty;
        end
    end

    assign dmem_data_out = r_readData;
    assign tx            = r_tx;
    assign irq_empty     = r_irqEmpty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx with the default parameters: BASE_ADDR 0xFFFFFFE0, depth 4, reset divisor 104.
// Register accesses run from a vector table.
// Frame timing, FIFO overflow, the pop/push race, a mid-frame divisor change and a mid-frame reset use hand-written sequences.

module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX = 32'hFFFF_FFE0;
    localparam logic [31:0] A_ST = 32'hFFFF_FFE4;
    localparam logic [31:0] A_BD = 32'hFFFF_FFE8;
    localparam logic [31:0] A_RS = 32'hFFFF_FFEC;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [2:0]  funct3;
    logic [31:0] dmem_data_out;
    logic        tx;
    logic        irq_empty;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expRead;
        string       name;
    } vec_t;

    vec_t vecs [22];

    // Bytes collected by the line receiver model
    logic [7:0] rxQ [$];
    logic [7:0] rxByte;
    int         tbDiv = 4;

    mmio_uart_tx dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .funct3        (funct3),
        .dmem_data_out (dmem_data_out),
        .tx            (tx),
        .irq_empty     (irq_empty)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Line receiver: on a low level it samples mid-bit at the divisor the bench expects.
    initial begin : rxModel
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                repeat (tbDiv / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (tbDiv) @(negedge clk);
                    rxByte[i] = tx;
                end
                repeat (tbDiv) @(negedge clk);
                rxQ.push_back(rxByte);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        dmem_address = addr;
        dmem_data_in = data;
        dmem_wren    = 1'b1;
        @(negedge clk);
        dmem_wren    = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] rd);
        @(negedge clk);
        dmem_address = addr;
        dmem_wren    = 1'b0;
        @(negedge clk);
        rd = dmem_data_out;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] rd;
        if (v.isWrite) begin
            busWrite(v.addr, v.data);
        end else begin
            busRead(v.addr, rd);
            checkOutput(v.name, rd, v.expRead);
        end
    endtask

    // Expected line level k cycles into an 8N1 frame of byte b at divisor div
    function automatic logic expTx(input logic [7:0] b, input int div, input int k);
        int bitNo;
        bitNo = k / div;
        if (bitNo == 0) return 1'b0;
        if (bitNo <= 8) return b[bitNo-1];
        return 1'b1;
    endfunction

    // Compares every cycle of one frame. The first sample is one cycle after the frame-start edge.
    task automatic captureFrame(input string name, input logic [7:0] b, input int div);
        int errs = 0;
        for (int k = 0; k < 10 * div; k++) begin
            @(negedge clk);
            if (tx !== expTx(b, div, k)) errs++;
        end
        checkOutput(name, 32'(errs), 32'd0);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        repeat (2) @(negedge clk);
        while (irq_empty !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, irq_empty}, 32'd1);
    endtask

    task automatic checkRxQueue(input string name, input logic [7:0] exp [$]);
        checkOutput({name, " count"}, 32'(rxQ.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            checkOutput($sformatf("%s byte %0d", name, i),
                        (i < rxQ.size()) ? {24'd0, rxQ[i]} : 32'hDEAD_BEEF, {24'd0, exp[i]});
        end
    endtask

    initial begin : main
        logic [31:0] rd;
        logic [7:0]  expQ [$];
        int          lowCount;

        reset        = 1'b0;
        dmem_wren    = 1'b0;
        dmem_address = 32'd0;
        dmem_data_in = 32'd0;
        funct3       = 3'b010;

        // Register access vectors
        vecs[0]  = '{1'b0, A_ST,          32'd0,          32'h0000_0002, "reset status"};
        vecs[1]  = '{1'b0, A_BD,          32'd0,          32'd104,       "reset bauddiv"};
        vecs[2]  = '{1'b0, A_TX,          32'd0,          32'd0,         "txdata reads zero"};
        vecs[3]  = '{1'b1, A_BD,          32'd1,          32'd0,         ""};
        vecs[4]  = '{1'b0, A_BD,          32'd0,          32'd2,         "bauddiv 1 clamps to 2"};
        vecs[5]  = '{1'b1, A_BD,          32'd0,          32'd0,         ""};
        vecs[6]  = '{1'b0, A_BD,          32'd0,          32'd2,         "bauddiv 0 clamps to 2"};
        vecs[7]  = '{1'b1, A_BD,          32'hABCD_0009,  32'd0,         ""};
        vecs[8]  = '{1'b0, A_BD,          32'd0,          32'd9,         "bauddiv upper bits drop"};
        vecs[9]  = '{1'b0, A_RS,          32'd0,          32'd0,         "reserved offset reads zero"};
        vecs[10] = '{1'b0, 32'hFFFF_FFDC, 32'd0,          32'd0,         "below window reads zero"};
        vecs[11] = '{1'b1, A_RS,          32'hFFFF_FFFF,  32'd0,         ""};
        vecs[12] = '{1'b1, 32'hFFFF_FFDC, 32'hFFFF_FFFF,  32'd0,         ""};
        vecs[13] = '{1'b1, 32'hFFFF_FFC0, 32'h0000_0055,  32'd0,         ""};
        vecs[14] = '{1'b1, 32'hFFFF_FFC8, 32'h0000_0020,  32'd0,         ""};
        vecs[15] = '{1'b0, A_BD,          32'd0,          32'd9,         "outside stores keep bauddiv"};
        vecs[16] = '{1'b0, A_ST,          32'd0,          32'h0000_0002, "outside stores keep status"};
        vecs[17] = '{1'b0, 32'hFFFF_FFC8, 32'd0,          32'd0,         "aliased bauddiv reads zero"};
        vecs[18] = '{1'b1, A_ST,          32'hFFFF_FFFF,  32'd0,         ""};
        vecs[19] = '{1'b0, A_ST,          32'd0,          32'h0000_0002, "status write is harmless"};
        vecs[20] = '{1'b1, A_BD,          32'd4,          32'd0,         ""};
        vecs[21] = '{1'b0, A_BD,          32'd0,          32'd4,         "bauddiv 4"};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        checkOutput("reset tx high", {31'd0, tx}, 32'd1);
        checkOutput("reset data_out", dmem_data_out, 32'd0);
        checkOutput("reset irq_empty", {31'd0, irq_empty}, 32'd1);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i]);
        end

        // Single frame 0xA5 at div 4: tx stays high until one edge after the push
        $display("[TB] single frame 0xA5");
        busWrite(A_TX, 32'h0000_00A5);
        checkOutput("tx high at push edge", {31'd0, tx}, 32'd1);
        captureFrame("frame A5 div4", 8'hA5, 4);
        @(negedge clk);
        checkOutput("irq low on stop end", {31'd0, irq_empty}, 32'd0);
        @(negedge clk);
        checkOutput("irq rises after stop", {31'd0, irq_empty}, 32'd1);
        checkOutput("tx idle high", {31'd0, tx}, 32'd1);

        // Six pushes during a frame: one transmitting, four queued, the last one dropped
        $display("[TB] overflow");
        rxQ.delete();
        busWrite(A_TX, 32'h11);
        busWrite(A_TX, 32'h22);
        busWrite(A_TX, 32'h33);
        busWrite(A_TX, 32'h44);
        busWrite(A_TX, 32'h55);
        busWrite(A_TX, 32'h66);
        busRead(A_ST, rd);
        checkOutput("status full+ovf", rd, 32'h0000_004D);
        busWrite(A_ST, 32'h0000_0008);
        busRead(A_ST, rd);
        checkOutput("status after w1c", rd, 32'h0000_0045);
        waitIdle("ovf drained", 600);
        expQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        checkRxQueue("ovf rx", expQ);

        // A push into a full FIFO on the same edge that a new frame pops the head
        $display("[TB] push on pop edge");
        rxQ.delete();
        busWrite(A_TX, 32'hA1);
        busWrite(A_TX, 32'hB2);
        busWrite(A_TX, 32'hC3);
        busWrite(A_TX, 32'hD4);
        busWrite(A_TX, 32'hE5);
        busRead(A_ST, rd);
        checkOutput("status full before race", rd, 32'h0000_0045);
        repeat (30) @(negedge clk);
        dmem_address = A_TX;
        dmem_data_in = 32'hF6;
        dmem_wren    = 1'b1;
        @(negedge clk);
        dmem_wren    = 1'b0;
        busRead(A_ST, rd);
        checkOutput("status after race push", rd, 32'h0000_0045);
        waitIdle("race drained", 800);
        expQ = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        checkRxQueue("race rx", expQ);

        // A divisor change mid-frame applies from the next frame
        $display("[TB] bauddiv change mid-frame");
        busWrite(A_TX, 32'h3C);
        fork
            begin
                captureFrame("frame 3C keeps div4", 8'h3C, 4);
                captureFrame("frame C3 uses div8", 8'hC3, 8);
            end
            begin
                busWrite(A_TX, 32'hC3);
                busWrite(A_BD, 32'd8);
            end
        join
        busRead(A_BD, rd);
        checkOutput("bauddiv 8", rd, 32'd8);
        waitIdle("div8 drained", 200);

        // Reset during DATA of a 0x00 frame, with two more bytes queued
        $display("[TB] reset mid-frame");
        busWrite(A_TX, 32'h00);
        busWrite(A_TX, 32'h77);
        busWrite(A_TX, 32'h88);
        repeat (14) @(negedge clk);
        checkOutput("tx low in data", {31'd0, tx}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("tx high at reset", {31'd0, tx}, 32'd1);
        checkOutput("irq at reset", {31'd0, irq_empty}, 32'd1);
        checkOutput("data_out at reset", dmem_data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        busRead(A_ST, rd);
        checkOutput("status after reset", rd, 32'h0000_0002);
        busRead(A_BD, rd);
        checkOutput("bauddiv after reset", rd, 32'd104);
        lowCount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) lowCount++;
        end
        checkOutput("fifo lost after reset", 32'(lowCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
